// File: rtl/duck_pkg.sv
// Shared definitions for the duck sprite sequencer: sprite shape table and FSM state encoding.
package duck_pkg;

    localparam int         SPRITE_PIXELS = 13;
    localparam logic [3:0] LAST_INDEX    = 4'(SPRITE_PIXELS - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ERASE = 2'd1,
        ST_MOVE  = 2'd2,
        ST_DRAW  = 2'd3
    } state_e;

    // Entries 13..15 are padding so any 4-bit index stays inside the table.
    localparam logic signed [3:0] SPRITE_DX [16] = '{
        4'sd0, 4'sd0, -4'sd1, -4'sd2, -4'sd3, -4'sd4, -4'sd5, -4'sd3,
        -4'sd3, -4'sd4, -4'sd4, -4'sd5, -4'sd5, 4'sd0, 4'sd0, 4'sd0
    };

    localparam logic signed [3:0] SPRITE_DY [16] = '{
        4'sd0, 4'sd1, 4'sd0, 4'sd0, 4'sd0, 4'sd0, 4'sd0, 4'sd1,
        -4'sd1, 4'sd2, -4'sd2, 4'sd3, -4'sd3, 4'sd0, 4'sd0, 4'sd0
    };

endpackage

// File: rtl/duck_offset_rom.sv
// Combinational lookup of the signed (dx,dy) offset of one sprite pixel from the anchor.
module duck_offset_rom
    import duck_pkg::*;
(
    input  logic [3:0]        idx_i,
    output logic signed [3:0] dx_o,
    output logic signed [3:0] dy_o
);

    assign dx_o = SPRITE_DX[idx_i];
    assign dy_o = SPRITE_DY[idx_i];

endmodule

// File: rtl/duck_sprite_sequencer.sv
// Per-frame erase/move/draw sequencer that streams duck sprite pixels to a VGA adapter.
// state | meaning: IDLE wait tick | ERASE 13 BG pixels | MOVE step anchor | DRAW 13 FG pixels
module duck_sprite_sequencer
    import duck_pkg::*;
#(
    parameter int unsigned X_MAX     = 159,
    parameter int unsigned Y_MAX     = 119,
    parameter logic [2:0]  FG_COLOUR = 3'b111,
    parameter logic [2:0]  BG_COLOUR = 3'b000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic [6:0] start_y,
    output logic [7:0] vga_x,
    output logic [6:0] vga_y,
    output logic [2:0] vga_colour,
    output logic       vga_plot,
    output logic       busy,
    output logic [7:0] duck_x,
    output logic       wrapped,
    output logic       overrun
);

    localparam logic [7:0]        X_LAST = 8'(X_MAX);
    localparam logic signed [8:0] X_LIM  = 9'(X_MAX);
    localparam logic signed [8:0] Y_LIM  = 9'(Y_MAX);

    state_e            state_q, state_d;
    logic [3:0]        idx_q, idx_d;
    logic              drawn_q, drawn_d;
    logic [7:0]        duck_x_q, duck_x_d;
    logic [6:0]        duck_y_q, duck_y_d;
    logic              y_loaded_q;
    logic [7:0]        vga_x_q, vga_x_d;
    logic [6:0]        vga_y_q, vga_y_d;
    logic [2:0]        vga_colour_q, vga_colour_d;
    logic              vga_plot_q, vga_plot_d;

    logic [6:0]        anchor_y;
    logic signed [3:0] dx, dy;
    logic signed [8:0] px_x, px_y;
    logic              px_visible;

    duck_offset_rom u_offset_rom (
        .idx_i (idx_q),
        .dx_o  (dx),
        .dy_o  (dy)
    );

    // Until the first edge after reset release the row anchor follows start_y directly.
    assign anchor_y   = y_loaded_q ? duck_y_q : start_y;
    assign px_x       = $signed({1'b0, duck_x_q}) + $signed({{5{dx[3]}}, dx});
    assign px_y       = $signed({2'b00, anchor_y}) + $signed({{5{dy[3]}}, dy});
    assign px_visible = !px_x[8] && (px_x <= X_LIM) && !px_y[8] && (px_y <= Y_LIM);

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        drawn_d      = drawn_q;
        duck_x_d     = duck_x_q;
        duck_y_d     = anchor_y;
        vga_x_d      = vga_x_q;
        vga_y_d      = vga_y_q;
        vga_colour_d = vga_colour_q;
        vga_plot_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (frame_tick) begin
                    idx_d   = '0;
                    state_d = drawn_q ? ST_ERASE : ST_DRAW;
                end
            end
            ST_ERASE, ST_DRAW: begin
                vga_x_d      = px_x[7:0];
                vga_y_d      = px_y[6:0];
                vga_colour_d = (state_q == ST_ERASE) ? BG_COLOUR : FG_COLOUR;
                vga_plot_d   = px_visible;
                if (idx_q == LAST_INDEX) begin
                    idx_d = '0;
                    if (state_q == ST_ERASE) begin
                        state_d = ST_MOVE;
                    end else begin
                        state_d = ST_IDLE;
                        drawn_d = 1'b1;
                    end
                end else begin
                    idx_d = idx_q + 4'd1;
                end
            end
            ST_MOVE: begin
                state_d = ST_DRAW;
                if (duck_x_q == X_LAST) begin
                    duck_x_d = '0;
                    duck_y_d = start_y;
                end else begin
                    duck_x_d = duck_x_q + 8'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            idx_q        <= '0;
            drawn_q      <= 1'b0;
            duck_x_q     <= '0;
            duck_y_q     <= '0;
            y_loaded_q   <= 1'b0;
            vga_x_q      <= '0;
            vga_y_q      <= '0;
            vga_colour_q <= BG_COLOUR;
            vga_plot_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            drawn_q      <= drawn_d;
            duck_x_q     <= duck_x_d;
            duck_y_q     <= duck_y_d;
            y_loaded_q   <= 1'b1;
            vga_x_q      <= vga_x_d;
            vga_y_q      <= vga_y_d;
            vga_colour_q <= vga_colour_d;
            vga_plot_q   <= vga_plot_d;
        end
    end

    assign vga_x      = vga_x_q;
    assign vga_y      = vga_y_q;
    assign vga_colour = vga_colour_q;
    assign vga_plot   = vga_plot_q;
    assign duck_x     = duck_x_q;
    assign busy       = (state_q != ST_IDLE);
    assign overrun    = frame_tick && busy;
    assign wrapped    = (state_q == ST_MOVE) && (duck_x_q == X_LAST);

endmodule
